seq_fsm: RTL and testbench
==========================

SEQ_FSM -- requirements
Module: seq_fsm

Interface
REQ-001 SHALL provide parameter PRE_LEN, default 2, cycles spent in PRE before ACT; legal range 1..256.
REQ-002 SHALL provide parameter ACT_LEN, default 1, cycles y1 is held high per ACT entry; legal range 1..256.
REQ-003 SHALL provide parameter TAIL_LEN, default 6, cycles spent in TAIL after ACT; legal range 1..256.
REQ-004 SHALL use one clock and an asynchronous active-low reset; elaboration SHALL fail if any parameter is outside 1..256.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 go  input  1  start request, sampled in IDLE and at TAIL end.
REQ-008 jmp  input  1  jump request, forces entry to ACT.
REQ-009 hold  input  1  stall, freezes state and counter.
REQ-010 repeat_en  input  1  auto-restart enable at TAIL end.
REQ-011 y1  output  1  high while in ACT.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 phase  output  2  current state code: IDLE=0, PRE=1, ACT=2, TAIL=3.

Function
REQ-015 SHALL implement a four-state FSM (IDLE, PRE, ACT, TAIL) with one shared 8-bit counter cnt.
REQ-016 cnt SHALL be cleared to 0 on every state entry and on every jmp re-entry to ACT.
REQ-017 IDLE: go=0 -> stay. go=1, jmp=1 -> ACT. go=1, jmp=0 -> PRE.
REQ-018 PRE: jmp=1 -> ACT. Else cnt==PRE_LEN-1 -> ACT. Else increment cnt.
REQ-019 ACT: jmp=1 -> stay in ACT with cnt=0, restarting the window. Else cnt==ACT_LEN-1 -> TAIL. Else increment cnt.
REQ-020 TAIL: jmp=1 -> ACT. Else, when cnt==TAIL_LEN-1: repeat_en=1 and go=1 -> PRE; otherwise -> IDLE. Else increment cnt.
REQ-021 In TAIL, jmp SHALL take priority over TAIL completion, and no done pulse SHALL occur on that cycle.
REQ-022 hold=1 SHALL freeze state and cnt in every state, including IDLE. hold=1 SHALL take priority over go, jmp and completion.
REQ-023 Outputs y1, busy and phase SHALL be Moore decodes of the registered state; no input-to-output combinational path.
REQ-024 done SHALL be registered and high for exactly the one cycle after the final TAIL cycle, whether the next state is IDLE or PRE.
REQ-025 With default parameters, hold=0 and repeat_en=0, the state sequence and y1 SHALL be cycle-identical to the legacy 10-state sequencer: PRE = S1..S2, ACT = S3, TAIL = S4..S9.
REQ-026 Minimum latency from IDLE with go=1, jmp=0 to y1 rising SHALL be PRE_LEN+1 cycles; with go=1, jmp=1 it SHALL be 1 cycle.
REQ-027 Counter compare SHALL be unsigned 8-bit. A value of 256 SHALL be encoded as terminal count 255 with no wrap beyond it.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, cnt=0, done=0, without waiting for a clock edge.
REQ-029 During reset, outputs SHALL read y1=0, busy=0, phase=0, done=0.
REQ-030 Reset asserted mid-ACT or mid-TAIL SHALL drop y1/busy asynchronously and SHALL emit no done pulse.
REQ-031 After rst_n rises, the first state update SHALL occur at the next rising clk edge.

Verification
REQ-032 Defaults, go=1 for one cycle, jmp=0: phase SHALL read 1,1,2,3x6,0. y1 SHALL be high for exactly 1 cycle, 3 cycles after go. done SHALL pulse once, 10 cycles after go.
REQ-033 ACT_LEN=4, go=1, then jmp=1 in the 3rd ACT cycle: y1 SHALL stay high 3+4=7 consecutive cycles before entering TAIL.
REQ-034 Defaults, hold=1 for 5 cycles during TAIL cnt=2: phase and cnt SHALL stay frozen. done SHALL be delayed by exactly 5 cycles.
REQ-035 repeat_en=1, go held at 1: PRE SHALL follow TAIL end directly, done SHALL pulse each pass, busy SHALL never drop, period = PRE_LEN+ACT_LEN+TAIL_LEN cycles.
REQ-036 rst_n pulled low asynchronously mid-ACT: y1 SHALL fall before the next clk edge. After release with go=0, phase SHALL stay 0.
REQ-037 jmp=1 on the final TAIL cycle: next phase SHALL be 2, with no done pulse.

Source files
------------

// File: rtl/seq_fsm.sv
// Four-phase sequencer (IDLE -> PRE -> ACT -> TAIL) with one shared phase counter,
// jump-to-ACT, stall, auto-repeat and a registered completion pulse.
module seq_fsm #(
    parameter int PRE_LEN  = 2,
    parameter int ACT_LEN  = 1,
    parameter int TAIL_LEN = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic       jmp,
    input  logic       hold,
    input  logic       repeat_en,
    output logic       y1,
    output logic       done,
    output logic       busy,
    output logic [1:0] phase
);

    if (PRE_LEN < 1 || PRE_LEN > 256 || ACT_LEN < 1 || ACT_LEN > 256 ||
        TAIL_LEN < 1 || TAIL_LEN > 256) begin : g_bad_params
        $error("seq_fsm: PRE_LEN, ACT_LEN and TAIL_LEN must each lie in 1..256");
    end

    // A length of 256 lands on terminal count 255, the top of the 8-bit counter.
    localparam logic [7:0] PRE_TC  = 8'(PRE_LEN - 1);
    localparam logic [7:0] ACT_TC  = 8'(ACT_LEN - 1);
    localparam logic [7:0] TAIL_TC = 8'(TAIL_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACT  = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    // NOTE: state uses non-blocking assignments and an asynchronous reset, so
    // every register updates together on the edge and clears without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!hold) begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d = jmp ? ACT : PRE;
                        cnt_d   = 8'd0;
                    end
                end
                PRE: begin
                    if (jmp || cnt_q == PRE_TC) begin
                        state_d = ACT;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ACT: begin
                    // A jump while already in ACT restarts the active window.
                    if (jmp) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q == ACT_TC) begin
                        state_d = TAIL;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                TAIL: begin
                    if (jmp) begin
                        state_d = ACT;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == TAIL_TC) begin
                        state_d = (repeat_en && go) ? PRE : IDLE;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign y1    = (state_q == ACT);
    assign busy  = (state_q != IDLE);
    assign phase = state_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_fsm.sv
// Self-checking bench for seq_fsm: a default instance and a long-window instance,
// table vectors, directed corner sequences and a randomized run against a phase-length model.
module tb_seq_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go, jmp, hold, repeat_en;
    logic       a_y1, a_done, a_busy;
    logic [1:0] a_phase;
    logic       b_y1, b_done, b_busy;
    logic [1:0] b_phase;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_fsm dut_a (
        .clk(clk), .rst_n(rst_n), .go(go), .jmp(jmp), .hold(hold), .repeat_en(repeat_en),
        .y1(a_y1), .done(a_done), .busy(a_busy), .phase(a_phase)
    );

    seq_fsm #(.PRE_LEN(1), .ACT_LEN(4), .TAIL_LEN(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go), .jmp(jmp), .hold(hold), .repeat_en(repeat_en),
        .y1(b_y1), .done(b_done), .busy(b_busy), .phase(b_phase)
    );

    // Model: current phase number, cycles already spent in it, and the done flag.
    typedef struct {
        int ph;
        int n;
        bit done;
    } model_t;

    model_t ma, mb;

    function automatic model_t step(input model_t m, input int pre_len, input int act_len,
                                    input int tail_len, input bit g, input bit j,
                                    input bit h, input bit r);
        int     len[4];
        model_t o;
        len = '{0, pre_len, act_len, tail_len};
        o = m;
        o.done = 1'b0;
        if (h) return o;
        if (m.ph == 0) begin
            if (g) begin
                o.ph = j ? 2 : 1;
                o.n  = 0;
            end
        end else if (j) begin
            o.ph = 2;
            o.n  = 0;
        end else if (m.n + 1 == len[m.ph]) begin
            o.n = 0;
            if (m.ph == 3) begin
                o.done = 1'b1;
                o.ph   = (r && g) ? 1 : 0;
            end else begin
                o.ph = m.ph + 1;
            end
        end else begin
            o.n = m.n + 1;
        end
        return o;
    endfunction

    function automatic logic [4:0] expect_of(input model_t m);
        return {2'(m.ph), m.ph == 2, m.ph != 0, m.done};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
        end
    endtask

    task automatic cycle(input bit g, input bit j, input bit h, input bit r);
        go = g; jmp = j; hold = h; repeat_en = r;
        @(posedge clk);
        ma = step(ma, 2, 1, 6, g, j, h, r);
        mb = step(mb, 1, 4, 256, g, j, h, r);
        #1;
        check("model_a", {27'd0, a_phase, a_y1, a_busy, a_done}, {27'd0, expect_of(ma)});
        check("model_b", {27'd0, b_phase, b_y1, b_busy, b_done}, {27'd0, expect_of(mb)});
    endtask

    task automatic do_reset();
        go = 1'b0; jmp = 1'b0; hold = 1'b0; repeat_en = 1'b0;
        rst_n = 1'b0;
        ma = '{0, 0, 1'b0};
        mb = '{0, 0, 1'b0};
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit       go, jmp, hold, rep;
        logic [1:0] ph;
        bit       y1, done;
    } vec_t;

    vec_t vecs[0:19];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, tail, ncyc, last_done, pulses, busy_drop;

        // Default-parameter stream: plain go pass, then go+jmp and a jump on the final TAIL cycle.
        vecs = '{
            '{1,0,0,0, 2'd1, 0, 0}, '{0,0,0,0, 2'd1, 0, 0}, '{0,0,0,0, 2'd2, 1, 0},
            '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0},
            '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0},
            '{0,0,0,0, 2'd0, 0, 1}, '{0,0,0,0, 2'd0, 0, 0}, '{1,1,0,0, 2'd2, 1, 0},
            '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0},
            '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0}, '{0,0,0,0, 2'd3, 0, 0},
            '{0,1,0,0, 2'd2, 1, 0}, '{0,0,0,0, 2'd3, 0, 0}
        };

        rst_n = 1'b0;
        go = 1'b0; jmp = 1'b0; hold = 1'b0; repeat_en = 1'b0;
        #2;
        check("reset_outputs_a", {28'd0, a_phase, a_y1, a_busy, a_done}, 32'd0);
        check("reset_outputs_b", {28'd0, b_phase, b_y1, b_busy, b_done}, 32'd0);
        do_reset();

        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].go, vecs[i].jmp, vecs[i].hold, vecs[i].rep);
            check($sformatf("vec%0d", i), {29'd0, a_phase, a_y1, a_done},
                  {29'd0, vecs[i].ph, vecs[i].y1, vecs[i].done});
        end

        // hold in IDLE outranks go
        do_reset();
        cycle(1, 0, 1, 0);
        check("hold_idle_phase", {30'd0, a_phase}, 32'd0);

        // hold for 5 cycles at TAIL cnt=2 delays done from cycle 10 to cycle 15
        do_reset();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        ncyc = 6;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0);
            ncyc++;
            check("hold_tail_frozen", {30'd0, a_phase, a_done}, {30'd0, 2'd3, 1'b0});
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 0);
            ncyc++;
            if (a_done) break;
        end
        check("hold_done_cycle", ncyc, 15);

        // Long ACT window restarted by jmp in its 3rd cycle, then a 256-cycle TAIL
        do_reset();
        cycle(1, 0, 0, 0);
        run = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            if (b_y1) run++;
        end
        cycle(0, 1, 0, 0);
        if (b_y1) run++;
        for (int i = 0; i < 20 && b_y1; i++) begin
            cycle(0, 0, 0, 0);
            if (b_y1) run++;
        end
        check("jmp_act_run", run, 7);
        check("jmp_act_then_tail", {30'd0, b_phase}, 32'd3);
        tail = 1;
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 0, 0);
            if (b_done) break;
            if (b_phase == 2'd3) tail++;
        end
        check("tail256_length", tail, 256);
        check("tail256_done", {30'd0, b_phase, b_done}, {30'd0, 2'd0, 1'b1});

        // Auto-repeat: done every 9 cycles, busy never drops
        do_reset();
        last_done = 0; pulses = 0; busy_drop = 0;
        for (int c = 1; c <= 40; c++) begin
            cycle(1, 0, 0, 1);
            if (!a_busy) busy_drop++;
            if (a_done) begin
                pulses++;
                if (last_done != 0) check("repeat_period", c - last_done, 9);
                else check("repeat_first_done", c, 10);
                last_done = c;
            end
        end
        check("repeat_pulses", pulses, 4);
        check("repeat_busy_drop", busy_drop, 0);

        // Asynchronous reset mid-ACT drops outputs before the next edge
        do_reset();
        cycle(1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        ma = '{0, 0, 1'b0};
        mb = '{0, 0, 1'b0};
        #1;
        check("async_reset_a", {28'd0, a_phase, a_y1, a_busy, a_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("post_reset_idle", {30'd0, a_phase}, 32'd0);
        end

        // Randomized stream against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
